nerv_mem_env: RTL and testbench

//  Parametrised data-memory and stall environment for the nerv core, used in both formal and simulation benches.
//  - Replaces the free-running random dmem_rdata/stall with a real word memory, so loads return previously stored data.
//  - Adds configurable access latency and a bounded-fairness mask on the external random stall.
//  - Sits between the core's dmem_* / stall ports and the bench's random-stall source.

---
 rtl/nerv_mem_env.sv | 114 +++++++++++
 tb/tb_nerv_mem_env.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nerv_mem_env.sv
// Word memory plus stall shaping for the nerv core's dmem port.
// Adds fixed per-request latency and a bound on external stall runs.
module nerv_mem_env #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 1,
    parameter int MAX_STALL  = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ext_stall,
    output logic        stall,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int RUN_W = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [RUN_W-1:0]  ext_run_q, ext_run_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       mem [DEPTH];

    logic [DEPTH_LOG2-1:0] idx;
    logic ext_ok;
    logic accept;
    logic is_read;
    logic unused_addr;

    assign idx         = dmem_addr[DEPTH_LOG2+1:2];
    assign unused_addr = ^{dmem_addr[31:DEPTH_LOG2+2], dmem_addr[1:0]};

    assign busy    = !reset && (state_q == BUSY);
    assign ext_ok  = ext_stall && !(MAX_STALL != 0 && ext_run_q == RUN_MAX);
    assign stall   = !reset && (busy || ext_ok);
    assign accept  = !reset && dmem_valid && !stall;
    assign is_read = (dmem_wstrb == 4'b0000);

    assign dmem_rdata = rdata_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ext_run_d = ext_run_q;
        rdata_d   = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (accept && LATENCY != 0) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase

        // run length only tracks stalls we did not cause ourselves
        if (!busy) begin
            if (stall && MAX_STALL != 0) begin
                ext_run_d = ext_run_q + RUN_W'(1);
            end else begin
                ext_run_d = '0;
            end
        end

        if (accept && is_read) begin
            rdata_d = mem[idx];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ext_run_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ext_run_q <= ext_run_d;
            rdata_q   <= rdata_d;
        end
    end

    // storage deliberately survives reset
    always_ff @(posedge clock) begin
        if (accept && !is_read) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_wstrb[i]) begin
                    mem[idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_nerv_mem_env.sv
// Bench for nerv_mem_env: two configurations against a cycle model.
// Directed scenarios first, then a long randomized run.
module tb_nerv_mem_env;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  ext   = '0;
    logic [1:0]  valid = '0;
    logic [1:0]  stall;
    logic [1:0]  busy;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [3:0]  wstrb [2];

    int n_checks = 0;
    int n_errors = 0;

    int dl_p  [2] = '{8, 4};
    int lat_p [2] = '{0, 3};
    int ms_p  [2] = '{0, 2};

    logic [31:0] m_mem   [2][256];
    logic [31:0] m_rdata [2];
    int          m_left  [2];
    int          m_run   [2];
    logic [1:0]  e_stall;
    logic [1:0]  e_busy;
    logic [1:0]  e_acc;

    always #5 clock = ~clock;

    nerv_mem_env #(
        .DEPTH_LOG2(8),
        .LATENCY   (0),
        .MAX_STALL (0)
    ) u_a (
        .clock     (clock),
        .reset     (reset),
        .ext_stall (ext[0]),
        .stall     (stall[0]),
        .dmem_valid(valid[0]),
        .dmem_addr (addr[0]),
        .dmem_wstrb(wstrb[0]),
        .dmem_wdata(wdata[0]),
        .dmem_rdata(rdata[0]),
        .busy      (busy[0])
    );

    nerv_mem_env #(
        .DEPTH_LOG2(4),
        .LATENCY   (3),
        .MAX_STALL (2)
    ) u_b (
        .clock     (clock),
        .reset     (reset),
        .ext_stall (ext[1]),
        .stall     (stall[1]),
        .dmem_valid(valid[1]),
        .dmem_addr (addr[1]),
        .dmem_wstrb(wstrb[1]),
        .dmem_wdata(wdata[1]),
        .dmem_rdata(rdata[1]),
        .busy      (busy[1])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        valid[i] = v;
        addr[i]  = a;
        wstrb[i] = s;
        wdata[i] = d;
    endtask

    // predict this cycle's outputs and compare
    task automatic settle();
        logic eok;
        #1;
        for (int i = 0; i < 2; i++) begin
            e_busy[i]  = !reset && (m_left[i] > 0);
            eok        = ext[i] && !(ms_p[i] != 0 && m_run[i] == ms_p[i]);
            e_stall[i] = !reset && (e_busy[i] || eok);
            e_acc[i]   = !reset && valid[i] && !e_stall[i];
            check($sformatf("stall%0d", i), 32'(stall[i]), 32'(e_stall[i]));
            check($sformatf("busy%0d", i), 32'(busy[i]), 32'(e_busy[i]));
            check($sformatf("rdata%0d", i), rdata[i], m_rdata[i]);
        end
    endtask

    // apply this cycle's effects to the model, then move one clock
    task automatic advance();
        int idx;
        logic [31:0] mask;
        for (int i = 0; i < 2; i++) begin
            idx  = int'((addr[i] >> 2) & ((32'd1 << dl_p[i]) - 32'd1));
            mask = {{8{wstrb[i][3]}}, {8{wstrb[i][2]}},
                    {8{wstrb[i][1]}}, {8{wstrb[i][0]}}};
            if (reset) begin
                m_left[i]  = 0;
                m_run[i]   = 0;
                m_rdata[i] = '0;
            end else begin
                if (e_busy[i]) begin
                    m_left[i]--;
                end else begin
                    m_run[i] = e_stall[i] ? m_run[i] + 1 : 0;
                end
                if (e_acc[i]) begin
                    m_left[i] = lat_p[i];
                    if (wstrb[i] == 4'b0000) begin
                        m_rdata[i] = m_mem[i][idx];
                    end else begin
                        m_mem[i][idx] = (m_mem[i][idx] & ~mask) | (wdata[i] & mask);
                    end
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_cycles(input int n);
        valid = '0;
        repeat (n) begin
            settle();
            advance();
        end
    endtask

    initial begin
        logic [31:0] exp;
        int ptr [2];
        int guard;
        logic [2:0] pat;

        for (int i = 0; i < 2; i++) begin
            drive(i, 1'b0, '0, '0, '0);
            m_rdata[i] = '0;
            m_left[i]  = 0;
            m_run[i]   = 0;
            ptr[i]     = 0;
            for (int w = 0; w < 256; w++) m_mem[i][w] = '0;
        end

        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);

        // reset held with external stall requested
        ext = 2'b11;
        repeat (2) begin
            settle();
            check("rst_stall_b", 32'(stall[1]), 32'd0);
            check("rst_rdata_a", rdata[0], 32'd0);
            advance();
        end
        reset = 1'b0;

        // fairness: bounded run on B, unbounded on A
        pat = 3'b011;
        for (int k = 0; k < 6; k++) begin
            settle();
            check("fair_b", 32'(stall[1]), 32'(pat[k % 3]));
            check("fair_a", 32'(stall[0]), 32'd1);
            advance();
        end
        ext = 2'b00;

        // fill both memories with known contents
        guard = 0;
        while ((ptr[0] < 256 || ptr[1] < 16) && guard < 1000) begin
            for (int i = 0; i < 2; i++) begin
                if (ptr[i] < (1 << dl_p[i])) begin
                    drive(i, 1'b1,
                          ($urandom << (dl_p[i] + 2)) | (32'(ptr[i]) << 2)
                          | ($urandom & 32'd3),
                          4'hF, $urandom);
                end else begin
                    valid[i] = 1'b0;
                end
            end
            settle();
            for (int i = 0; i < 2; i++) if (e_acc[i]) ptr[i]++;
            advance();
            guard++;
        end
        idle_cycles(4);

        // zero-latency write then read
        drive(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        settle();
        check("wr_nostall", 32'(stall[0]), 32'd0);
        advance();
        drive(0, 1'b1, 32'h10, 4'h0, 32'h0);
        settle();
        check("rd_nostall", 32'(stall[0]), 32'd0);
        advance();
        valid[0] = 1'b0;
        settle();
        check("rd_data", rdata[0], 32'hDEADBEEF);
        advance();

        // byte strobe through an aliased address
        drive(0, 1'b1, 32'h20, 4'hF, 32'h11223344);
        settle();
        advance();
        drive(0, 1'b1, 32'h420, 4'b0001, 32'h000000AA);
        settle();
        advance();
        drive(0, 1'b1, 32'h20, 4'h0, 32'h0);
        settle();
        advance();
        valid[0] = 1'b0;
        settle();
        check("alias", rdata[0], 32'h112233AA);
        advance();

        // latency window on B, request during BUSY must be dropped
        idle_cycles(4);
        exp = m_mem[1][5];
        drive(1, 1'b1, 32'h14, 4'h0, 32'h0);
        settle();
        check("lat_acc", 32'(stall[1]), 32'd0);
        advance();
        drive(1, 1'b1, 32'h14, 4'hF, 32'h0BADF00D);
        for (int k = 1; k <= 3; k++) begin
            settle();
            check("lat_busy", 32'(busy[1]), 32'd1);
            check("lat_stall", 32'(stall[1]), 32'd1);
            check("lat_hold", rdata[1], exp);
            advance();
            valid[1] = 1'b0;
        end
        settle();
        check("lat_done_busy", 32'(busy[1]), 32'd0);
        check("lat_done_stall", 32'(stall[1]), 32'd0);
        check("lat_done_data", rdata[1], exp);
        advance();
        drive(1, 1'b1, 32'h14, 4'h0, 32'h0);
        settle();
        advance();
        valid[1] = 1'b0;
        settle();
        check("lat_ignored", rdata[1], exp);
        advance();

        // reset on the second BUSY cycle
        idle_cycles(4);
        exp = m_mem[1][6];
        drive(1, 1'b1, 32'h18, 4'h0, 32'h0);
        settle();
        advance();
        valid[1] = 1'b0;
        settle();
        advance();
        reset = 1'b1;
        settle();
        check("rst_mid_busy", 32'(busy[1]), 32'd0);
        check("rst_mid_stall", 32'(stall[1]), 32'd0);
        advance();
        reset = 1'b0;
        settle();
        check("rst_after_busy", 32'(busy[1]), 32'd0);
        check("rst_after_data", rdata[1], 32'd0);
        advance();
        drive(1, 1'b1, 32'h18, 4'h0, 32'h0);
        settle();
        advance();
        valid[1] = 1'b0;
        settle();
        check("rst_keep_mem", rdata[1], exp);
        advance();

        // randomized traffic
        repeat (3000) begin
            reset = ($urandom % 64) == 0;
            for (int i = 0; i < 2; i++) begin
                ext[i] = ($urandom % 3) == 0;
                drive(i, 1'($urandom % 2), $urandom,
                      (($urandom % 3) == 0) ? 4'h0 : 4'($urandom),
                      $urandom);
            end
            settle();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
